// File: rtl/rf68000_nic_master_arb.sv
// Round-robin arbiter that shares one global slave bus among the ring NIC
// master ports. One owner per bus cycle, grant held until termination, the
// termination is routed back to the owner only, and hung cycles are aborted
// with a forced error after TIMEOUT busy clocks.
module rf68000_nic_master_arb #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 512
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_MASTERS-1:0]      req_cyc_i,
    input  logic [NUM_MASTERS-1:0]      req_stb_i,
    input  logic [NUM_MASTERS-1:0]      req_we_i,
    input  logic [4*NUM_MASTERS-1:0]    req_sel_i,
    input  logic [8*NUM_MASTERS-1:0]    req_asid_i,
    input  logic [32*NUM_MASTERS-1:0]   req_adr_i,
    input  logic [32*NUM_MASTERS-1:0]   req_dat_i,
    input  logic [6*NUM_MASTERS-1:0]    req_core_i,
    input  logic [NUM_MASTERS-1:0]      req_mmus_i,
    input  logic [NUM_MASTERS-1:0]      req_ios_i,
    input  logic [NUM_MASTERS-1:0]      req_iops_i,
    output logic [NUM_MASTERS-1:0]      req_ack_o,
    output logic [NUM_MASTERS-1:0]      req_err_o,
    output logic [NUM_MASTERS-1:0]      req_vpa_o,
    output logic [31:0]                 req_dat_o,
    output logic                        m_cyc_o,
    output logic                        m_stb_o,
    output logic                        m_we_o,
    output logic [3:0]                  m_sel_o,
    output logic [7:0]                  m_asid_o,
    output logic [31:0]                 m_adr_o,
    output logic [31:0]                 m_dat_o,
    output logic [5:0]                  m_core_o,
    output logic                        m_mmus_o,
    output logic                        m_ios_o,
    output logic                        m_iops_o,
    input  logic                        m_ack_i,
    input  logic                        m_err_i,
    input  logic                        m_vpa_i,
    input  logic [31:0]                 m_dat_i,
    output logic [NUM_MASTERS-1:0]      gnt_o
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0]          TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [NUM_MASTERS-1:0] GNT_ONE  = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                 state_r, state_s;
    logic [IW-1:0]          last_r, last_s;
    logic [IW-1:0]          owner_r, owner_s;
    logic [NUM_MASTERS-1:0] gnt_r, gnt_s;
    logic [TW-1:0]          timer_r, timer_s;
    logic                   cyc_r, cyc_s, stb_r, stb_s, we_r, we_s;
    logic [3:0]             sel_r, sel_s;
    logic [7:0]             asid_r, asid_s;
    logic [31:0]            adr_r, adr_s, dat_r, dat_s;
    logic [5:0]             core_r, core_s;
    logic                   mmus_r, mmus_s, ios_r, ios_s, iops_r, iops_s;
    logic [31:0]            rdat_r, rdat_s;

    logic [NUM_MASTERS-1:0] req_vld_s;
    logic                   pick_found_s;
    logic [IW-1:0]          pick_idx_s;
    logic [IW-1:0]          src_s;
    logic [31:0]            src_int_s;
    logic                   owner_cyc_s, resp_any_s, timeout_s, busy_live_s;

    assign req_vld_s   = req_cyc_i & req_stb_i;
    assign owner_cyc_s = req_cyc_i[owner_r];
    assign resp_any_s  = m_ack_i | m_err_i | m_vpa_i;
    assign timeout_s   = (timer_r == TMO_LAST);
    assign busy_live_s = (state_r == ST_BUSY) && owner_cyc_s;
    // While idle the request fields come from the pick, otherwise from the owner.
    assign src_s       = (state_r == ST_IDLE) ? pick_idx_s : owner_r;
    assign src_int_s   = 32'(src_s);

    // Round-robin search starting one past the last owner.
    always_comb begin
        int idx_v;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        idx_v        = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx_v = (int'(last_r) + i) % NUM_MASTERS;
            if (!pick_found_s && req_vld_s[idx_v]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = IW'(idx_v);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Termination routed to the owner only, ack > err > vpa > timeout error.
    always_comb begin
        req_ack_o = '0;
        req_err_o = '0;
        req_vpa_o = '0;
        if (busy_live_s) begin
            if (m_ack_i) begin
                req_ack_o[owner_r] = 1'b1;
            end else if (m_err_i) begin
                req_err_o[owner_r] = 1'b1;
            end else if (m_vpa_i) begin
                req_vpa_o[owner_r] = 1'b1;
            end else if (timeout_s) begin
                req_err_o[owner_r] = 1'b1;
            end else begin
                req_ack_o = '0;
            end
        end else begin
            req_ack_o = '0;
        end
    end

    // Next-state and next-bus-value logic of the arbitration FSM.
    always_comb begin
        state_s = state_r;
        last_s  = last_r;
        owner_s = owner_r;
        gnt_s   = gnt_r;
        timer_s = timer_r;
        cyc_s   = cyc_r;
        stb_s   = stb_r;
        we_s    = we_r;
        sel_s   = sel_r;
        asid_s  = asid_r;
        adr_s   = adr_r;
        dat_s   = dat_r;
        core_s  = core_r;
        mmus_s  = mmus_r;
        ios_s   = ios_r;
        iops_s  = iops_r;
        rdat_s  = (state_r == ST_BUSY && m_ack_i) ? m_dat_i : rdat_r;

        case (state_r)
            ST_IDLE: begin
                if (pick_found_s) begin
                    state_s = ST_BUSY;
                    owner_s = pick_idx_s;
                    gnt_s   = GNT_ONE << pick_idx_s;
                    timer_s = '0;
                    cyc_s   = 1'b1;
                    stb_s   = 1'b1;
                    we_s    = req_we_i[src_s];
                    sel_s   = req_sel_i[src_int_s*32'd4 +: 4];
                    asid_s  = req_asid_i[src_int_s*32'd8 +: 8];
                    adr_s   = req_adr_i[src_int_s*32'd32 +: 32];
                    dat_s   = req_dat_i[src_int_s*32'd32 +: 32];
                    core_s  = req_core_i[src_int_s*32'd6 +: 6];
                    mmus_s  = req_mmus_i[src_s];
                    ios_s   = req_ios_i[src_s];
                    iops_s  = req_iops_i[src_s];
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (resp_any_s || !owner_cyc_s || timeout_s) begin
                    cyc_s  = 1'b0;
                    stb_s  = 1'b0;
                    we_s   = 1'b0;
                    sel_s  = 4'h0;
                    mmus_s = 1'b0;
                    ios_s  = 1'b0;
                    iops_s = 1'b0;
                    if (!resp_any_s && !owner_cyc_s) begin
                        // Abandoned cycle: no response, ownership ends at once.
                        state_s = ST_IDLE;
                        gnt_s   = '0;
                        last_s  = owner_r;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end else begin
                    stb_s   = req_stb_i[src_s];
                    we_s    = req_we_i[src_s];
                    sel_s   = req_sel_i[src_int_s*32'd4 +: 4];
                    asid_s  = req_asid_i[src_int_s*32'd8 +: 8];
                    adr_s   = req_adr_i[src_int_s*32'd32 +: 32];
                    dat_s   = req_dat_i[src_int_s*32'd32 +: 32];
                    core_s  = req_core_i[src_int_s*32'd6 +: 6];
                    mmus_s  = req_mmus_i[src_s];
                    ios_s   = req_ios_i[src_s];
                    iops_s  = req_iops_i[src_s];
                    timer_s = timer_r + TW'(1);
                end
            end
            ST_RELEASE: begin
                if (!owner_cyc_s) begin
                    state_s = ST_IDLE;
                    gnt_s   = '0;
                    last_s  = owner_r;
                end else begin
                    state_s = ST_RELEASE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = '0;
                cyc_s   = 1'b0;
                stb_s   = 1'b0;
                we_s    = 1'b0;
                sel_s   = 4'h0;
                mmus_s  = 1'b0;
                ios_s   = 1'b0;
                iops_s  = 1'b0;
            end
        endcase
    end

    // State and bus-output registers; reset clears the bus without a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            last_r  <= IW'(NUM_MASTERS - 1);
            owner_r <= '0;
            gnt_r   <= '0;
            timer_r <= '0;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            sel_r   <= 4'h0;
            asid_r  <= 8'h00;
            adr_r   <= 32'h0000_0000;
            dat_r   <= 32'h0000_0000;
            core_r  <= 6'h00;
            mmus_r  <= 1'b0;
            ios_r   <= 1'b0;
            iops_r  <= 1'b0;
            rdat_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            last_r  <= last_s;
            owner_r <= owner_s;
            gnt_r   <= gnt_s;
            timer_r <= timer_s;
            cyc_r   <= cyc_s;
            stb_r   <= stb_s;
            we_r    <= we_s;
            sel_r   <= sel_s;
            asid_r  <= asid_s;
            adr_r   <= adr_s;
            dat_r   <= dat_s;
            core_r  <= core_s;
            mmus_r  <= mmus_s;
            ios_r   <= ios_s;
            iops_r  <= iops_s;
            rdat_r  <= rdat_s;
        end
    end

    assign gnt_o     = gnt_r;
    assign m_cyc_o   = cyc_r;
    assign m_stb_o   = stb_r;
    assign m_we_o    = we_r;
    assign m_sel_o   = sel_r;
    assign m_asid_o  = asid_r;
    assign m_adr_o   = adr_r;
    assign m_dat_o   = dat_r;
    assign m_core_o  = core_r;
    assign m_mmus_o  = mmus_r;
    assign m_ios_o   = ios_r;
    assign m_iops_o  = iops_r;
    assign req_dat_o = rdat_r;

endmodule

// File: tb/tb_rf68000_nic_master_arb.sv
// Bench for rf68000_nic_master_arb: transaction-phase reference model checked
// every cycle plus directed scenarios with literal expectations.
module tb_rf68000_nic_master_arb;

    localparam int N   = 4;
    localparam int TMO = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req_cyc, req_stb, req_we, req_mmus, req_ios, req_iops;
    logic [4*N-1:0]  req_sel;
    logic [8*N-1:0]  req_asid;
    logic [32*N-1:0] req_adr, req_dat;
    logic [6*N-1:0]  req_core;
    logic [N-1:0]    req_ack, req_err, req_vpa, gnt;
    logic [31:0]     req_dat_out;
    logic            m_cyc, m_stb, m_we, m_mmus, m_ios, m_iops;
    logic [3:0]      m_sel;
    logic [7:0]      m_asid;
    logic [31:0]     m_adr, m_dat;
    logic [5:0]      m_core;
    logic            m_ack, m_err, m_vpa;
    logic [31:0]     m_dat_in;

    rf68000_nic_master_arb #(.NUM_MASTERS(N), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_cyc_i(req_cyc), .req_stb_i(req_stb), .req_we_i(req_we),
        .req_sel_i(req_sel), .req_asid_i(req_asid), .req_adr_i(req_adr),
        .req_dat_i(req_dat), .req_core_i(req_core), .req_mmus_i(req_mmus),
        .req_ios_i(req_ios), .req_iops_i(req_iops),
        .req_ack_o(req_ack), .req_err_o(req_err), .req_vpa_o(req_vpa),
        .req_dat_o(req_dat_out),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
        .m_asid_o(m_asid), .m_adr_o(m_adr), .m_dat_o(m_dat), .m_core_o(m_core),
        .m_mmus_o(m_mmus), .m_ios_o(m_ios), .m_iops_o(m_iops),
        .m_ack_i(m_ack), .m_err_i(m_err), .m_vpa_i(m_vpa), .m_dat_i(m_dat_in),
        .gnt_o(gnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase: 0 idle, 1 busy, 2 release) --
    int          mo_phase, mo_owner, mo_last, mo_cnt, mo_k;
    logic        mo_cyc, mo_stb, mo_we, mo_mmus, mo_ios, mo_iops;
    logic [3:0]  mo_sel;
    logic [7:0]  mo_asid;
    logic [31:0] mo_adr, mo_dat, mo_rdat;
    logic [5:0]  mo_core;
    logic [N-1:0] e_ack, e_err, e_vpa, e_gnt, one_hot;

    task automatic mo_snap(input int k);
        mo_cyc  = 1'b1;
        mo_stb  = req_stb[k];
        mo_we   = req_we[k];
        mo_sel  = req_sel[4*k +: 4];
        mo_asid = req_asid[8*k +: 8];
        mo_adr  = req_adr[32*k +: 32];
        mo_dat  = req_dat[32*k +: 32];
        mo_core = req_core[6*k +: 6];
        mo_mmus = req_mmus[k];
        mo_ios  = req_ios[k];
        mo_iops = req_iops[k];
    endtask

    task automatic mo_clear();
        mo_cyc = 1'b0; mo_stb = 1'b0; mo_we = 1'b0; mo_sel = 4'h0;
        mo_mmus = 1'b0; mo_ios = 1'b0; mo_iops = 1'b0;
    endtask

    // Compare DUT against the model, then advance the model with the inputs
    // that the next rising edge will sample (inputs only move after posedge).
    always @(negedge clk) begin
        if (rst) begin
            mo_phase = 0; mo_owner = -1; mo_last = N - 1; mo_cnt = 0;
            mo_clear();
            mo_asid = 8'h00; mo_adr = 32'h0; mo_dat = 32'h0; mo_core = 6'h0;
            mo_rdat = 32'h0;
        end else begin
            e_ack = '0; e_err = '0; e_vpa = '0; e_gnt = '0; one_hot = 4'b0001;
            if (mo_phase != 0) e_gnt = one_hot << mo_owner;
            if (mo_phase == 1 && req_cyc[mo_owner]) begin
                if (m_ack)              e_ack[mo_owner] = 1'b1;
                else if (m_err)         e_err[mo_owner] = 1'b1;
                else if (m_vpa)         e_vpa[mo_owner] = 1'b1;
                else if (mo_cnt == TMO) e_err[mo_owner] = 1'b1;
            end
            chk("gnt", gnt, e_gnt);
            chk("m_cyc", m_cyc, mo_cyc);
            chk("m_stb", m_stb, mo_stb);
            chk("m_we", m_we, mo_we);
            chk("m_sel", m_sel, mo_sel);
            chk("m_qual", {m_mmus, m_ios, m_iops}, {mo_mmus, mo_ios, mo_iops});
            chk("req_ack", req_ack, e_ack);
            chk("req_err", req_err, e_err);
            chk("req_vpa", req_vpa, e_vpa);
            chk("req_dat", req_dat_out, mo_rdat);
            if (mo_cyc) begin
                chk("m_adr", m_adr, mo_adr);
                chk("m_dat", m_dat, mo_dat);
                chk("m_asid_core", {m_asid, m_core}, {mo_asid, mo_core});
            end
            // advance
            if (mo_phase == 0) begin
                for (int i = 1; i <= N; i++) begin
                    mo_k = (mo_last + i) % N;
                    if (mo_owner < 0 && req_cyc[mo_k] && req_stb[mo_k]) mo_owner = mo_k;
                end
                if (mo_owner >= 0) begin
                    mo_phase = 1; mo_cnt = 1; mo_snap(mo_owner);
                end
            end else if (mo_phase == 1) begin
                if (m_ack) mo_rdat = m_dat_in;
                if (m_ack || m_err || m_vpa) begin
                    mo_clear(); mo_phase = 2;
                end else if (!req_cyc[mo_owner]) begin
                    mo_clear(); mo_last = mo_owner; mo_owner = -1; mo_phase = 0;
                end else if (mo_cnt == TMO) begin
                    mo_clear(); mo_phase = 2;
                end else begin
                    mo_cnt++; mo_snap(mo_owner);
                end
            end else begin
                if (!req_cyc[mo_owner]) begin
                    mo_last = mo_owner; mo_owner = -1; mo_phase = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        req_cyc[k] = cyc; req_stb[k] = cyc; req_we[k] = we;
        req_sel[4*k +: 4]   = 4'hF;
        req_asid[8*k +: 8]  = 8'h10 + 8'(k);
        req_adr[32*k +: 32] = a;
        req_dat[32*k +: 32] = d;
        req_core[6*k +: 6]  = 6'(3*k + 1);
        req_mmus[k] = k[0]; req_ios[k] = k[1]; req_iops[k] = we;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_cyc = '0; req_stb = '0; req_we = '0; req_mmus = '0; req_ios = '0;
        req_iops = '0; req_sel = '0; req_asid = '0; req_adr = '0; req_dat = '0;
        req_core = '0; m_ack = 1'b0; m_err = 1'b0; m_vpa = 1'b0; m_dat_in = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int   order [8];
    int   exp_ord [5] = '{0, 1, 2, 3, 0};
    int   n_order, busy_cnt;
    logic prev_g, got;

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_cyc", m_cyc, 1'b0);
        chk("rst_dat", req_dat_out, 32'h0);
        chk("rst_adr", m_adr, 32'h0);

        // ---- 1: master 2 read, ack 3 clocks later ----
        set_m(2, 1'b1, 1'b0, 32'h2000_0010, 32'h0);
        mid(); chk("t1_pre_cyc", m_cyc, 1'b0);
        step(); mid();
        chk("t1_cyc", m_cyc, 1'b1);
        chk("t1_gnt", gnt, 4'b0100);
        chk("t1_adr", m_adr, 32'h2000_0010);
        step(); req_sel[11:8] = 4'h3;
        step(); step();
        m_ack = 1'b1; m_dat_in = 32'hDEAD_BEEF;
        mid(); chk("t1_ack", req_ack, 4'b0100);
        step(); m_ack = 1'b0; set_m(2, 1'b0, 1'b0, 32'h2000_0010, 32'h0);
        mid();
        chk("t1_rdat", req_dat_out, 32'hDEAD_BEEF);
        chk("t1_ack_gone", req_ack, 4'b0000);
        chk("t1_cyc_rel", m_cyc, 1'b0);
        step(); mid(); chk("t1_gnt_idle", gnt, 4'b0000);

        // ---- 2: all four request continuously, 1-clock ack ----
        do_reset();
        for (int k = 0; k < N; k++) set_m(k, 1'b1, k[0], 32'h1000_0000 + 32'(k), 32'hA0 + 32'(k));
        n_order = 0; prev_g = 1'b0;
        for (int c = 0; c < 80 && n_order < 5; c++) begin
            step();
            if (gnt != 4'b0000 && !prev_g) begin
                for (int j = 0; j < N; j++) if (gnt[j]) order[n_order] = j;
                n_order++;
            end
            prev_g = (gnt != 4'b0000);
            m_dat_in = 32'h5000_0000 + 32'(c);
            m_ack = m_cyc && !m_ack;
            for (int k = 0; k < N; k++) begin
                req_cyc[k] = !(gnt[k] && !m_cyc);
                req_stb[k] = req_cyc[k];
            end
        end
        chk("t2_grants", n_order, 5);
        for (int i = 0; i < 5; i++) chk("t2_order", order[i], exp_ord[i]);

        // ---- 3: master 1 write, slave silent -> timeout error ----
        do_reset();
        set_m(1, 1'b1, 1'b1, 32'h3000_0004, 32'hCAFE_0001);
        busy_cnt = 0; got = 1'b0;
        for (int c = 0; c < 700 && !got; c++) begin
            mid();
            if (m_cyc) busy_cnt++;
            if (req_err[1]) got = 1'b1;
        end
        chk("t3_err_seen", got, 1'b1);
        chk("t3_busy_cycles", busy_cnt, 512);
        chk("t3_err_vec", req_err, 4'b0010);
        mid();
        chk("t3_cyc_off", m_cyc, 1'b0);
        chk("t3_err_pulse", req_err, 4'b0000);
        step(); req_cyc[1] = 1'b0; req_stb[1] = 1'b0;
        step();

        // ---- 4: master 3 abandons, next grant to master 0 ----
        do_reset();
        set_m(3, 1'b1, 1'b0, 32'h4000_0000, 32'h0);
        step(); mid(); chk("t4_gnt3", gnt, 4'b1000);
        step(); req_cyc[3] = 1'b0; req_stb[3] = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h4000_0100, 32'h0);
        step(); mid();
        chk("t4_cyc_drop", m_cyc, 1'b0);
        chk("t4_no_err", req_err, 4'b0000);
        step(); mid();
        chk("t4_gnt0", gnt, 4'b0001);
        chk("t4_cyc0", m_cyc, 1'b1);

        // ---- 5: ack+err together, then vpa alone ----
        do_reset();
        set_m(0, 1'b1, 1'b0, 32'h5000_0000, 32'h0);
        step(); step();
        m_ack = 1'b1; m_err = 1'b1; m_dat_in = 32'h1234_5678;
        mid();
        chk("t5_ack", req_ack, 4'b0001);
        chk("t5_err", req_err, 4'b0000);
        step(); m_ack = 1'b0; m_err = 1'b0; req_cyc[0] = 1'b0; req_stb[0] = 1'b0;
        mid(); chk("t5_rdat", req_dat_out, 32'h1234_5678);
        step(); set_m(1, 1'b1, 1'b0, 32'h5000_0040, 32'h0);
        step(); m_vpa = 1'b1; m_dat_in = 32'hBADB_AD00;
        mid();
        chk("t5_vpa", req_vpa, 4'b0010);
        chk("t5_vpa_ack", req_ack, 4'b0000);
        chk("t5_vpa_err", req_err, 4'b0000);
        step(); m_vpa = 1'b0; req_cyc[1] = 1'b0; req_stb[1] = 1'b0;
        mid(); chk("t5_rdat_kept", req_dat_out, 32'h1234_5678);

        // ---- 6: asynchronous reset mid-BUSY ----
        do_reset();
        set_m(1, 1'b1, 1'b0, 32'h6000_0000, 32'h0);
        step(); step(); mid(); chk("t6_busy", m_cyc, 1'b1);
        @(posedge clk); #2;
        rst = 1'b1; m_ack = 1'b1;
        req_cyc[1] = 1'b0; req_stb[1] = 1'b0;
        set_m(0, 1'b1, 1'b0, 32'h6000_0010, 32'h0);
        set_m(2, 1'b1, 1'b0, 32'h6000_0020, 32'h0);
        #1;
        chk("t6_cyc_async", m_cyc, 1'b0);
        chk("t6_gnt_async", gnt, 4'b0000);
        chk("t6_ack_async", req_ack, 4'b0000);
        chk("t6_stb_async", m_stb, 1'b0);
        m_ack = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        step(); mid();
        chk("t6_gnt_first", gnt, 4'b0001);
        chk("t6_adr_first", m_adr, 32'h6000_0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
